// File: rtl/error_log_arbiter_if.sv
// Error-log bus: reporter offers in, arbitrated head record out to the log writer.
interface error_log_arbiter_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = 64
);
  localparam int unsigned SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic                      log_valid;
  logic                      log_ready;
  logic [DATA_W-1:0]         log_data;
  logic [SRC_W-1:0]          log_src;

  // Driver side: the reporters plus the log writer.
  modport master (
    output src_valid, src_data, log_ready,
    input  src_ready, log_valid, log_data, log_src
  );

  // Arbiter side.
  modport slave (
    input  src_valid, src_data, log_ready,
    output src_ready, log_valid, log_data, log_src
  );
endinterface

// File: rtl/error_log_arbiter.sv
// Round-robin arbiter of NUM_SRC error reporters into a record FIFO, drained over
// valid/ready, with a coalescing FSM raising one interrupt per batch of records.
module error_log_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TMR_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  error_log_arbiter_if.slave            bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [TMR_W-1:0]              stall_count,
  input  logic [$clog2(FIFO_DEPTH):0]   irq_threshold,
  input  logic [TMR_W-1:0]              irq_timeout,
  output logic                          irq,
  input  logic                          irq_ack,
  input  logic                          stall_clear
);
  localparam int unsigned SRC_W = $clog2(NUM_SRC);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPend = 2'd1;
  localparam logic [1:0] StFire = 2'd2;

  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [TMR_W-1:0]  stall_q, stall_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [1:0]        state_q, state_d;
  logic              irq_q;

  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [SRC_W-1:0]  mem_src  [FIFO_DEPTH];

  logic              grant_found;
  logic [SRC_W-1:0]  grant_idx;
  logic [DATA_W-1:0] grant_data;
  logic [NUM_SRC-1:0] ready;
  logic              accept;
  logic              pop;
  logic [LVL_W-1:0]  thr_eff;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    logic [SRC_W:0] sum;
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(i);
      if (sum >= (SRC_W+1)'(NUM_SRC)) sum = sum - (SRC_W+1)'(NUM_SRC);
      if (!grant_found && bus.src_valid[sum[SRC_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = sum[SRC_W-1:0];
      end
    end
  end

  // Select the winner's payload with constant slices only.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (SRC_W'(i) == grant_idx) grant_data = bus.src_data[i*DATA_W +: DATA_W];
    end
  end

  // No bypass: a full FIFO refuses even when the head is popped this cycle.
  assign accept = grant_found && (level_q < LVL_W'(FIFO_DEPTH));
  assign pop    = (level_q != '0) && bus.log_ready;

  // One-hot ready for the accepted source only.
  always_comb begin
    ready = '0;
    if (accept) ready[grant_idx] = 1'b1;
  end

  assign bus.src_ready = ready;
  assign bus.log_valid = (level_q != '0);
  assign bus.log_data  = (level_q != '0) ? mem_data[rd_ptr_q] : '0;
  assign bus.log_src   = (level_q != '0) ? mem_src[rd_ptr_q]  : '0;
  assign fifo_level    = level_q;
  assign stall_count   = stall_q;
  assign irq           = irq_q;

  // Pointer, level and stall next-state.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);
    end

    level_d = level_q;
    if (accept && !pop)      level_d = level_q + LVL_W'(1);
    else if (!accept && pop) level_d = level_q - LVL_W'(1);

    stall_d = stall_q;
    if (stall_clear) begin
      stall_d = '0;
    end else if ((|bus.src_valid) && !accept && (stall_q != '1)) begin
      stall_d = stall_q + TMR_W'(1);
    end
  end

  // Coalescing FSM: batch records until threshold or timeout, then hold irq until ack.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    thr_eff = (irq_threshold == '0) ? LVL_W'(1) : irq_threshold;
    case (state_q)
      StIdle: begin
        if (level_q != '0) begin
          state_d = StPend;
          timer_d = '0;
        end
      end
      StPend: begin
        if (timer_q != '1) timer_d = timer_q + TMR_W'(1);
        if ((level_q >= thr_eff) || (timer_q >= irq_timeout)) begin
          state_d = StFire;
        end else if (level_q == '0) begin
          state_d = StIdle;
        end
      end
      StFire: begin
        if (irq_ack) begin
          if (level_q == '0) begin
            state_d = StIdle;
          end else begin
            state_d = StPend;
            timer_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state with asynchronous reset; irq is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      stall_q  <= '0;
      timer_q  <= '0;
      state_q  <= StIdle;
      irq_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      level_q  <= level_d;
      stall_q  <= stall_d;
      timer_q  <= timer_d;
      state_q  <= state_d;
      irq_q    <= (state_d == StFire);
      if (accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Record storage; entries are only observable through the level-gated head.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_data[wr_ptr_q] <= grant_data;
      mem_src[wr_ptr_q]  <= grant_idx;
    end
  end

endmodule

// File: tb/tb_error_log_arbiter.sv
// Randomized bench for error_log_arbiter against a queue-based reference model.
module tb_error_log_arbiter;
  localparam int NSRC  = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 8;
  localparam int TW    = 16;
  localparam int TMAX  = (1 << TW) - 1;

  typedef struct {
    int          src;
    logic [63:0] data;
  } rec_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  fifo_level;
  logic [15:0] stall_count;
  logic [3:0]  irq_threshold;
  logic [15:0] irq_timeout;
  logic        irq;
  logic        irq_ack;
  logic        stall_clear;

  error_log_arbiter_if #(.NUM_SRC(NSRC), .DATA_W(DW)) bus ();

  error_log_arbiter #(
    .NUM_SRC(NSRC), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .TMR_W(TW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .fifo_level   (fifo_level),
    .stall_count  (stall_count),
    .irq_threshold(irq_threshold),
    .irq_timeout  (irq_timeout),
    .irq          (irq),
    .irq_ack      (irq_ack),
    .stall_clear  (stall_clear)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: record queue, next-priority source, stall count, interrupt state.
  rec_t q[$];
  int   m_rr;
  int   m_stall;
  int   m_timer;
  bit   m_pend;
  bit   m_irq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rr = 0; m_stall = 0; m_timer = 0; m_pend = 0; m_irq = 0;
  endtask

  // Drive one cycle of stimulus, compare outputs, then advance the model.
  task automatic step(input logic [3:0] vfix, input int v_pct, input int r_pct,
                      input int ack_pct, input int clr_pct, input int thr, input int tmo);
    int          g;
    bit          found;
    bit          acc;
    int          lvl;
    int          thr_eff;
    bit          fire;
    logic [3:0]  exp_ready;
    rec_t        r;
    @(negedge clk);
    for (int i = 0; i < NSRC; i++) begin
      bus.src_valid[i] = vfix[i] | (int'($urandom_range(99)) < v_pct);
      bus.src_data[i*DW +: DW] = {$urandom, $urandom};
    end
    bus.log_ready = (int'($urandom_range(99)) < r_pct);
    irq_ack       = (int'($urandom_range(99)) < ack_pct);
    stall_clear   = (int'($urandom_range(99)) < clr_pct);
    irq_threshold = 4'(thr);
    irq_timeout   = 16'(tmo);
    #1;
    found = 0; g = 0;
    for (int k = 0; k < NSRC; k++) begin
      if (!found && bus.src_valid[(m_rr + k) % NSRC]) begin
        found = 1;
        g = (m_rr + k) % NSRC;
      end
    end
    lvl = q.size();
    acc = found && (lvl < DEPTH);
    exp_ready = '0;
    if (acc) exp_ready[g] = 1'b1;
    check("src_ready",   64'(bus.src_ready), 64'(exp_ready));
    check("log_valid",   64'(bus.log_valid), 64'(lvl != 0));
    check("log_data",    bus.log_data, (lvl != 0) ? q[0].data : 64'd0);
    check("log_src",     64'(bus.log_src), (lvl != 0) ? 64'(q[0].src) : 64'd0);
    check("fifo_level",  64'(fifo_level), 64'(lvl));
    check("stall_count", 64'(stall_count), 64'(m_stall));
    check("irq",         64'(irq), 64'(m_irq));

    if (lvl != 0 && bus.log_ready) void'(q.pop_front());
    if (acc) begin
      r.src  = g;
      r.data = bus.src_data[g*DW +: DW];
      q.push_back(r);
      m_rr = (g + 1) % NSRC;
    end
    if (stall_clear) m_stall = 0;
    else if ((|bus.src_valid) && !acc && m_stall < TMAX) m_stall++;

    thr_eff = (thr == 0) ? 1 : thr;
    if (m_irq) begin
      if (irq_ack) begin
        m_irq = 0;
        if (lvl != 0) begin m_pend = 1; m_timer = 0; end
      end
    end else if (m_pend) begin
      fire = (lvl >= thr_eff) || (m_timer >= tmo);
      if (m_timer < TMAX) m_timer++;
      if (fire) begin m_pend = 0; m_irq = 1; end
      else if (lvl == 0) m_pend = 0;
    end else if (lvl != 0) begin
      m_pend = 1; m_timer = 0;
    end
  endtask

  task automatic run(input int n, input logic [3:0] vfix, input int v_pct, input int r_pct,
                     input int ack_pct, input int thr, input int tmo);
    for (int c = 0; c < n; c++) step(vfix, v_pct, r_pct, ack_pct, 0, thr, tmo);
  endtask

  // Hold reset across an edge and confirm every output sits at its reset value.
  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.src_valid = '0;
    bus.log_ready = 1'b0;
    irq_ack       = 1'b0;
    stall_clear   = 1'b0;
    #1;
    check("rst_level",     64'(fifo_level), 64'd0);
    check("rst_log_valid", 64'(bus.log_valid), 64'd0);
    check("rst_log_data",  bus.log_data, 64'd0);
    check("rst_log_src",   64'(bus.log_src), 64'd0);
    check("rst_irq",       64'(irq), 64'd0);
    check("rst_stall",     64'(stall_count), 64'd0);
    check("rst_ready",     64'(bus.src_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.src_valid = '0;
    bus.src_data  = '0;
    bus.log_ready = 1'b0;
    irq_ack       = 1'b0;
    stall_clear   = 1'b0;
    irq_threshold = 4'd8;
    irq_timeout   = 16'd1000;
    model_reset();
    do_reset();

    // All sources requesting with a free-running sink: strict rotation 0,1,2,3,...
    run(12, 4'hF, 0, 100, 0, 8, 1000);
    run(4, 4'h0, 0, 100, 100, 8, 1000);
    // Sink blocked: source 0 fills the FIFO, then five refused cycles.
    run(13, 4'b0001, 0, 0, 0, 8, 1000);
    // Full FIFO with a pop and a request together: pop only, push on the next cycle.
    run(3, 4'b0001, 0, 100, 0, 8, 1000);
    run(10, 4'h0, 0, 100, 100, 8, 1000);
    // Threshold of 3 records fires quickly; ack drops irq.
    run(3, 4'b0001, 0, 0, 0, 3, 100);
    run(4, 4'h0, 0, 0, 0, 3, 100);
    run(2, 4'h0, 0, 0, 100, 3, 100);
    run(10, 4'h0, 0, 100, 100, 3, 100);
    // Single record waits out a timeout of 10; ack with the record still held re-arms.
    run(1, 4'b0010, 0, 0, 0, 8, 10);
    run(14, 4'h0, 0, 0, 0, 8, 10);
    run(1, 4'h0, 0, 0, 100, 8, 10);
    run(14, 4'h0, 0, 0, 0, 8, 10);
    run(10, 4'h0, 0, 100, 100, 8, 10);
    // Threshold 0 behaves as 1; timeout 0 fires straight from PEND.
    run(6, 4'h0, 30, 0, 0, 0, 1000);
    run(6, 4'h0, 0, 100, 100, 8, 0);

    // Mixed random traffic with drifting threshold/timeout and occasional stall clears.
    for (int blk = 0; blk < 60; blk++) begin
      int thr;
      int tmo;
      thr = int'($urandom_range(8));
      tmo = int'($urandom_range(20));
      for (int c = 0; c < 50; c++) begin
        step(4'h0, 35, int'($urandom_range(20, 90)), 20, 2, thr, tmo);
      end
    end

    // Reset mid-operation with a backlog and a pending interrupt.
    run(5, 4'b0100, 0, 0, 0, 3, 100);
    run(4, 4'h0, 0, 0, 0, 3, 100);
    do_reset();
    run(8, 4'hF, 0, 100, 0, 8, 1000);
    for (int c = 0; c < 400; c++) step(4'h0, 40, 50, 15, 2, 4, 6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
